hazard_fwd_ctrl: RTL and testbench

- Parametrised forwarding and load-use hazard controller for the in-order RISC-V pipeline.
- Sits beside the D stage. Compares NUM_SRC decoded source registers against the destinations of in-flight instructions in E, M and W.
- Produces per-source bypass selects, plus an IF/ID stall and ID/EX flush sequenced by a load-use FSM that handles multi-cycle load latency.
- Also registers the selects into E and honours branch flushes.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/fwd_src_match.sv | 51 +++++
 rtl/hazard_fwd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding controller
package hazard_pkg;

    // Operand bypass source selected for a D-stage source register
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    // Load-use sequencer states
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } lu_state_e;

    // x0 is hardwired to zero and never produces or consumes a dependency
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - per-source dependency match and bypass select
module fwd_src_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rs_use,
    input  logic              d_valid,
    input  logic              e_valid,
    input  logic              e_reg_write,
    input  logic              e_mem_read,
    input  logic [REG_AW-1:0] e_rd_addr,
    input  logic              m_valid,
    input  logic              m_reg_write,
    input  logic              m_mem_read,
    input  logic [REG_AW-1:0] m_rd_addr,
    input  logic              w_valid,
    input  logic              w_reg_write,
    input  logic [REG_AW-1:0] w_rd_addr,
    input  logic              lu_busy,
    output logic [1:0]        fwd_sel,
    output logic              load_hazard
);

    logic src_live;
    logic hit_e;
    logic hit_m;
    logic hit_w;

    // A nonzero rs equal to rd implies rd is nonzero, so x0 writers never match
    assign src_live = d_valid & rs_use & (rs_addr != REG_AW'(REG_ZERO));
    assign hit_e    = src_live & e_valid & e_reg_write & (e_rd_addr == rs_addr);
    assign hit_m    = src_live & m_valid & m_reg_write & (m_rd_addr == rs_addr);
    assign hit_w    = src_live & w_valid & w_reg_write & (w_rd_addr == rs_addr);

    assign load_hazard = hit_e & e_mem_read;

    // Youngest usable producer wins; a load in E or a still-pending load in M is skipped
    always_comb begin
        fwd_sel = FWD_RF;
        if (hit_e && !e_mem_read) begin
            fwd_sel = FWD_E;
        end else if (hit_m && !(m_mem_read && lu_busy)) begin
            fwd_sel = FWD_M;
        end else if (hit_w) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - forwarding selects and load-use stall sequencing (optional HAZARD_PERF_EN counters)
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ext_flush,
    input  logic                      D_valid,
    input  logic [NUM_SRC*REG_AW-1:0] D_rs_addr,
    input  logic [NUM_SRC-1:0]        D_rs_use,
    input  logic                      E_valid,
    input  logic                      E_RegWrite,
    input  logic                      E_MemRead,
    input  logic [REG_AW-1:0]         E_rd_addr,
    input  logic                      M_valid,
    input  logic                      M_RegWrite,
    input  logic                      M_MemRead,
    input  logic [REG_AW-1:0]         M_rd_addr,
    input  logic                      W_valid,
    input  logic                      W_RegWrite,
    input  logic [REG_AW-1:0]         W_rd_addr,
    output logic [2*NUM_SRC-1:0]      D_fwd_sel,
    output logic [2*NUM_SRC-1:0]      E_fwd_sel,
    output logic                      stall_ifid,
    output logic                      flush_idex,
    output logic                      lu_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               perf_stall_cyc,
    output logic [31:0]               perf_fwd_evt
`endif
);

    lu_state_e            state;
    lu_state_e            state_nx;
    logic [2:0]           cnt;
    logic [2:0]           cnt_nx;
    logic [NUM_SRC-1:0]   src_haz;
    logic [2*NUM_SRC-1:0] sel_raw;
    logic                 hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(.REG_AW(REG_AW)) u_match (
            .rs_addr     (D_rs_addr[i*REG_AW +: REG_AW]),
            .rs_use      (D_rs_use[i]),
            .d_valid     (D_valid),
            .e_valid     (E_valid),
            .e_reg_write (E_RegWrite),
            .e_mem_read  (E_MemRead),
            .e_rd_addr   (E_rd_addr),
            .m_valid     (M_valid),
            .m_reg_write (M_RegWrite),
            .m_mem_read  (M_MemRead),
            .m_rd_addr   (M_rd_addr),
            .w_valid     (W_valid),
            .w_reg_write (W_RegWrite),
            .w_rd_addr   (W_rd_addr),
            .lu_busy     (lu_busy),
            .fwd_sel     (sel_raw[2*i +: 2]),
            .load_hazard (src_haz[i])
        );
    end

    assign hazard    = |src_haz;
    assign lu_busy   = (state == LU_STALL);
    assign D_fwd_sel = rst ? '0 : sel_raw;

    // Stall and bubble always travel together; ext_flush owns the pipe when it fires
    always_comb begin
        stall_ifid = 1'b0;
        if (!rst && !ext_flush) begin
            stall_ifid = lu_busy || hazard;
        end
    end

    assign flush_idex = stall_ifid;

    // Load-use sequencer: the detect cycle plus LOAD_LAT counted cycles in LU_STALL
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (ext_flush) begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 0)) begin
                        state_nx = LU_STALL;
                        cnt_nx   = 3'(LOAD_LAT);
                    end
                end
                LU_STALL: begin
                    cnt_nx = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 3'd0;
                end
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Carry the selects into E; a bubble or flushed slot carries no bypass
    always_ff @(posedge clk) begin
        if (rst || ext_flush || flush_idex) begin
            E_fwd_sel <= '0;
        end else begin
            E_fwd_sel <= D_fwd_sel;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] fwd_inc;

    // Number of sources actually bypassed this cycle
    always_comb begin
        fwd_inc = 32'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (D_fwd_sel[2*i +: 2] != FWD_RF) begin
                fwd_inc = fwd_inc + 32'd1;
            end
        end
    end

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= 32'd0;
            perf_fwd_evt   <= 32'd0;
        end else begin
            if (stall_ifid) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (D_valid && !stall_ifid) begin
                perf_fwd_evt <= perf_fwd_evt + fwd_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - self-checking bench for hazard_fwd_ctrl at LOAD_LAT 0, 2 and 3
module tb_hazard_fwd_ctrl;

    localparam int NS = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ext_flush = 1'b0;
    logic          D_valid = 1'b0;
    logic [NS*AW-1:0] D_rs_addr = '0;
    logic [NS-1:0] D_rs_use = '0;
    logic          E_valid = 1'b0, E_RegWrite = 1'b0, E_MemRead = 1'b0;
    logic [AW-1:0] E_rd_addr = '0;
    logic          M_valid = 1'b0, M_RegWrite = 1'b0, M_MemRead = 1'b0;
    logic [AW-1:0] M_rd_addr = '0;
    logic          W_valid = 1'b0, W_RegWrite = 1'b0;
    logic [AW-1:0] W_rd_addr = '0;

    logic [3:0]  dsel [3];
    logic [3:0]  esel [3];
    logic        stl  [3];
    logic        fls  [3];
    logic        bsy  [3];
    logic [31:0] pst  [3];
    logic [31:0] pfe  [3];

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state: remaining counted stall cycles per instance
    int          rem      [3] = '{0, 0, 0};
    logic [3:0]  exp_esel [3] = '{4'h0, 4'h0, 4'h0};
    logic [31:0] exp_pst  [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] exp_pfe  [3] = '{32'd0, 32'd0, 32'd0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_fwd_ctrl #(
            .NUM_SRC  (NS),
            .REG_AW   (AW),
            .LOAD_LAT ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .ext_flush  (ext_flush),
            .D_valid    (D_valid),
            .D_rs_addr  (D_rs_addr),
            .D_rs_use   (D_rs_use),
            .E_valid    (E_valid),
            .E_RegWrite (E_RegWrite),
            .E_MemRead  (E_MemRead),
            .E_rd_addr  (E_rd_addr),
            .M_valid    (M_valid),
            .M_RegWrite (M_RegWrite),
            .M_MemRead  (M_MemRead),
            .M_rd_addr  (M_rd_addr),
            .W_valid    (W_valid),
            .W_RegWrite (W_RegWrite),
            .W_rd_addr  (W_rd_addr),
            .D_fwd_sel  (dsel[g]),
            .E_fwd_sel  (esel[g]),
            .stall_ifid (stl[g]),
            .flush_idex (fls[g]),
            .lu_busy    (bsy[g])
`ifdef HAZARD_PERF_EN
            ,
            .perf_stall_cyc (pst[g]),
            .perf_fwd_evt   (pfe[g])
`endif
        );
    end

`ifndef HAZARD_PERF_EN
    initial begin
        for (int k = 0; k < 3; k++) begin
            pst[k] = '0;
            pfe[k] = '0;
        end
    end
`endif

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic [1:0] m_src(input int i, input bit busy);
        logic [4:0] rs;
        rs = D_rs_addr[i*AW +: AW];
        if (rst || !D_valid || !D_rs_use[i] || rs == 5'd0) return 2'd0;
        if (E_valid && E_RegWrite && E_rd_addr == rs && !E_MemRead) return 2'd1;
        if (M_valid && M_RegWrite && M_rd_addr == rs && !(M_MemRead && busy)) return 2'd2;
        if (W_valid && W_RegWrite && W_rd_addr == rs) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_sel(input bit busy);
        return {m_src(1, busy), m_src(0, busy)};
    endfunction

    function automatic bit m_haz();
        logic [4:0] rs;
        for (int i = 0; i < NS; i++) begin
            rs = D_rs_addr[i*AW +: AW];
            if (D_valid && D_rs_use[i] && rs != 5'd0 && E_valid && E_RegWrite
                && E_MemRead && E_rd_addr == rs) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_stall(input int k);
        return !rst && !ext_flush && (rem[k] > 0 || m_haz());
    endfunction

    function automatic int n_nz(input logic [3:0] s);
        return ((s[1:0] != 2'd0) ? 1 : 0) + ((s[3:2] != 2'd0) ? 1 : 0);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || ext_flush) rem[k] <= 0;
            else if (rem[k] > 0) rem[k] <= rem[k] - 1;
            else if (m_haz()) rem[k] <= lat_of(k);
            exp_esel[k] <= (rst || ext_flush || m_stall(k)) ? 4'h0 : m_sel(rem[k] > 0);
            if (rst) begin
                exp_pst[k] <= 32'd0;
                exp_pfe[k] <= 32'd0;
            end else begin
                if (m_stall(k)) exp_pst[k] <= exp_pst[k] + 32'd1;
                if (D_valid && !m_stall(k)) exp_pfe[k] <= exp_pfe[k] + 32'(n_nz(m_sel(rem[k] > 0)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ext_flush = 0; D_valid = 0; D_rs_addr = '0; D_rs_use = '0;
        E_valid = 0; E_RegWrite = 0; E_MemRead = 0; E_rd_addr = '0;
        M_valid = 0; M_RegWrite = 0; M_MemRead = 0; M_rd_addr = '0;
        W_valid = 0; W_RegWrite = 0; W_rd_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
    endtask

    task automatic e_load_x7();
        E_valid = 1; E_RegWrite = 1; E_MemRead = 1; E_rd_addr = 5'd7;
    endtask

    task automatic m_load_x7();
        E_valid = 0; E_MemRead = 0;
        M_valid = 1; M_RegWrite = 1; M_MemRead = 1; M_rd_addr = 5'd7;
    endtask

    task automatic test_reset();
        rst = 1;
        D_valid = 1; D_rs_addr = {5'd7, 5'd5}; D_rs_use = 2'b11;
        E_valid = 1; E_RegWrite = 1; E_rd_addr = 5'd5;
        W_valid = 1; W_RegWrite = 1; W_rd_addr = 5'd7;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dsel[k] !== 4'h0 || stl[k] !== 1'b0 || fls[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_comb inst%0d: got sel=%h stall=%b flush=%b want 0/0/0", k, dsel[k], stl[k], fls[k]);
            end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bsy[k] !== 1'b0 || esel[k] !== 4'h0 || pst[k] !== 32'd0 || pfe[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_regs inst%0d: got busy=%b esel=%h perf=%0d/%0d want 0", k, bsy[k], esel[k], pst[k], pfe[k]);
            end
        end
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_fwd_e();
        do_reset();
        E_valid = 1; E_RegWrite = 1; E_rd_addr = 5'd5;
        D_valid = 1; D_rs_addr = {5'd0, 5'd5}; D_rs_use = 2'b01;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dsel[k] !== 4'h1 || stl[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL fwd_e inst%0d: got sel=%h stall=%b want 1/0", k, dsel[k], stl[k]);
            end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (esel[k] !== 4'h1) begin
                n_fail++;
                $display("FAIL fwd_e_reg inst%0d: got %h want 1", k, esel[k]);
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        E_valid = 1; E_RegWrite = 1; E_rd_addr = 5'd5;
        M_valid = 1; M_RegWrite = 1; M_rd_addr = 5'd5;
        D_valid = 1; D_rs_addr = {5'd5, 5'd0}; D_rs_use = 2'b10;
        #1;
        n_cmp++;
        if (dsel[0] !== 4'h4) begin
            n_fail++;
            $display("FAIL prio_e_over_m: got %h want 4", dsel[0]);
        end
        E_rd_addr = 5'd0; M_rd_addr = 5'd0; D_rs_addr = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (dsel[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL prio_x0: got %h want 0", dsel[0]);
        end
        E_rd_addr = 5'd3; M_rd_addr = 5'd9; W_valid = 1; W_RegWrite = 1; W_rd_addr = 5'd5;
        D_rs_addr = {5'd9, 5'd5}; D_rs_use = 2'b11;
        #1;
        n_cmp++;
        if (dsel[1] !== 4'hB) begin
            n_fail++;
            $display("FAIL prio_indep: got %h want b", dsel[1]);
        end
        D_rs_use = 2'b01;
        #1;
        n_cmp++;
        if (dsel[2] !== 4'h3) begin
            n_fail++;
            $display("FAIL prio_use_gate: got %h want 3", dsel[2]);
        end
    endtask

    task automatic test_load_use_lat2();
        do_reset();
        e_load_x7();
        D_valid = 1; D_rs_addr = {5'd0, 5'd7}; D_rs_use = 2'b01;
        #1;
        n_cmp++;
        if (stl[1] !== 1'b1 || fls[1] !== 1'b1 || bsy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat2_detect: got stall=%b flush=%b busy=%b want 1/1/0", stl[1], fls[1], bsy[1]);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            m_load_x7();
            #1;
            n_cmp++;
            if (stl[1] !== 1'b1 || fls[1] !== 1'b1 || bsy[1] !== 1'b1 || dsel[1] !== 4'h0 || esel[1] !== 4'h0) begin
                n_fail++;
                $display("FAIL lat2_hold%0d: got stall=%b flush=%b busy=%b sel=%h esel=%h want 1/1/1/0/0",
                         c, stl[1], fls[1], bsy[1], dsel[1], esel[1]);
            end
        end
        tick();
        M_valid = 0; M_MemRead = 0; W_valid = 1; W_RegWrite = 1; W_rd_addr = 5'd7;
        #1;
        n_cmp++;
        if (stl[1] !== 1'b0 || bsy[1] !== 1'b0 || dsel[1] !== 4'h3) begin
            n_fail++;
            $display("FAIL lat2_release: got stall=%b busy=%b sel=%h want 0/0/3", stl[1], bsy[1], dsel[1]);
        end
        tick();
        n_cmp++;
        if (esel[1] !== 4'h3) begin
            n_fail++;
            $display("FAIL lat2_esel: got %h want 3", esel[1]);
        end
    endtask

    task automatic test_load_use_lat0();
        do_reset();
        e_load_x7();
        D_valid = 1; D_rs_addr = {5'd7, 5'd0}; D_rs_use = 2'b10;
        #1;
        n_cmp++;
        if (stl[0] !== 1'b1 || fls[0] !== 1'b1 || bsy[0] !== 1'b0 || dsel[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL lat0_detect: got stall=%b flush=%b busy=%b sel=%h want 1/1/0/0", stl[0], fls[0], bsy[0], dsel[0]);
        end
        tick();
        m_load_x7();
        #1;
        n_cmp++;
        if (stl[0] !== 1'b0 || dsel[0] !== 4'h8) begin
            n_fail++;
            $display("FAIL lat0_fwd_m: got stall=%b sel=%h want 0/8", stl[0], dsel[0]);
        end
        tick();
        n_cmp++;
        if (esel[0] !== 4'h8) begin
            n_fail++;
            $display("FAIL lat0_esel: got %h want 8", esel[0]);
        end
    endtask

    task automatic test_ext_flush();
        do_reset();
        e_load_x7();
        D_valid = 1; D_rs_addr = {5'd0, 5'd7}; D_rs_use = 2'b01;
        #1;
        n_cmp++;
        if (stl[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL xf_detect: got stall=%b want 1", stl[2]);
        end
        tick();
        m_load_x7();
        ext_flush = 1;
        #1;
        n_cmp++;
        if (stl[2] !== 1'b0 || fls[2] !== 1'b0 || bsy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL xf_suppress: got stall=%b flush=%b busy=%b want 0/0/1", stl[2], fls[2], bsy[2]);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (bsy[2] !== 1'b0 || stl[2] !== 1'b0 || esel[2] !== 4'h0) begin
            n_fail++;
            $display("FAIL xf_after: got busy=%b stall=%b esel=%h want 0/0/0", bsy[2], stl[2], esel[2]);
        end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        e_load_x7();
        W_valid = 1; W_RegWrite = 1; W_rd_addr = 5'd4;
        D_valid = 1; D_rs_addr = {5'd4, 5'd7}; D_rs_use = 2'b11;
        tick();
        n_cmp++;
        if (bsy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_enter: got busy=%b want 1", bsy[2]);
        end
        rst = 1;
        #1;
        n_cmp++;
        if (stl[2] !== 1'b0 || fls[2] !== 1'b0 || dsel[2] !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid_comb: got stall=%b flush=%b sel=%h want 0/0/0", stl[2], fls[2], dsel[2]);
        end
        tick();
        rst = 0;
        idle_inputs();
        #1;
        n_cmp++;
        if (bsy[2] !== 1'b0 || stl[2] !== 1'b0 || esel[2] !== 4'h0 || pst[2] !== 32'd0 || pfe[2] !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got busy=%b stall=%b esel=%h perf=%0d/%0d want all 0",
                     bsy[2], stl[2], esel[2], pst[2], pfe[2]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(63) == 0);
            ext_flush  = ($urandom_range(15) == 0);
            D_valid    = ($urandom_range(4) != 0);
            D_rs_addr  = {5'($urandom_range(3)), 5'($urandom_range(3))};
            D_rs_use   = 2'($urandom_range(3));
            E_valid    = 1'($urandom); E_RegWrite = 1'($urandom); E_MemRead = 1'($urandom);
            E_rd_addr  = 5'($urandom_range(3));
            M_valid    = 1'($urandom); M_RegWrite = 1'($urandom); M_MemRead = 1'($urandom);
            M_rd_addr  = 5'($urandom_range(3));
            W_valid    = 1'($urandom); W_RegWrite = 1'($urandom);
            W_rd_addr  = 5'($urandom_range(3));
            #1;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dsel[k] !== m_sel(rem[k] > 0) || stl[k] !== m_stall(k) || fls[k] !== m_stall(k)
                    || bsy[k] !== (rem[k] > 0) || esel[k] !== exp_esel[k]) begin
                    n_fail++;
                    $display("FAIL rand n=%0d inst%0d: got sel=%h st=%b fl=%b busy=%b esel=%h want sel=%h st=%b busy=%b esel=%h",
                             n, k, dsel[k], stl[k], fls[k], bsy[k], esel[k],
                             m_sel(rem[k] > 0), m_stall(k), (rem[k] > 0), exp_esel[k]);
                end
`ifdef HAZARD_PERF_EN
                n_cmp++;
                if (pst[k] !== exp_pst[k] || pfe[k] !== exp_pfe[k]) begin
                    n_fail++;
                    $display("FAIL rand_perf n=%0d inst%0d: got %0d/%0d want %0d/%0d",
                             n, k, pst[k], pfe[k], exp_pst[k], exp_pfe[k]);
                end
`endif
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_fwd_e();
        test_priority();
        test_load_use_lat2();
        test_load_use_lat0();
        test_ext_flush();
        test_rst_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
